// File: rtl/eth_phy_10g_tx_test_ctrl_if.sv
// rtl/eth_phy_10g_tx_test_ctrl_if.sv - encoded 64b/66b block bus (data + sync header)
// Ports (modports):
//   master : drives data, hdr
//   slave  : receives data, hdr
interface eth_phy_10g_tx_test_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] data;
  logic [HDR_WIDTH-1:0]  hdr;

  modport master (output data, output hdr);
  modport slave  (input data, input hdr);
endinterface

// File: rtl/eth_phy_10g_tx_test_ctrl.sv
// rtl/eth_phy_10g_tx_test_ctrl.sv - 10GBASE-R TX sequencer between normal traffic and PRBS31 test mode
// Ports:
//   clk, rst          TX clock (one block per cycle), synchronous active-high reset
//   enc_tx            encoded block from the 64b/66b encoder (slave)
//   encoded_tx        block to the PHY TX IF, registered (master)
//   cfg_prbs31_req    level request for PRBS31 test mode
//   tx_prbs31_enable  PRBS31 enable to the TX IF
//   mac_tx_pause      asks the MAC to stop starting frames
//   prbs31_active     high while the TX IF is sending PRBS31
//   drain_timeout     one-cycle pulse when the frame-boundary wait timed out
module eth_phy_10g_tx_test_ctrl #(
  parameter int DATA_WIDTH    = 64,
  parameter int HDR_WIDTH     = 2,
  parameter int PRBS31_ENABLE = 0,
  parameter int IDLE_COUNT    = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  eth_phy_10g_tx_test_ctrl_if.slave         enc_tx,
  eth_phy_10g_tx_test_ctrl_if.master        encoded_tx,
  output logic                              tx_prbs31_enable,
  input  logic                              cfg_prbs31_req,
  output logic                              mac_tx_pause,
  output logic                              prbs31_active,
  output logic                              drain_timeout
);

  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $error("eth_phy_10g_tx_test_ctrl: DATA_WIDTH must be 64");
  end
  if (HDR_WIDTH != 2) begin : g_bad_hdr_width
    $error("eth_phy_10g_tx_test_ctrl: HDR_WIDTH must be 2");
  end
  if (IDLE_COUNT < 1 || IDLE_COUNT > 65535) begin : g_bad_idle_count
    $error("eth_phy_10g_tx_test_ctrl: IDLE_COUNT out of range 1..65535");
  end
  if (DRAIN_TIMEOUT < 1 || DRAIN_TIMEOUT > 65535) begin : g_bad_drain_timeout
    $error("eth_phy_10g_tx_test_ctrl: DRAIN_TIMEOUT out of range 1..65535");
  end

  localparam logic [63:0] IDLE_DATA  = 64'h0000_0000_0000_001E;
  localparam logic [1:0]  IDLE_HDR   = 2'b10;
  localparam logic [15:0] IDLE_LAST  = 16'(IDLE_COUNT - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_TIMEOUT - 1);
  localparam bit          TEST_EN    = (PRBS31_ENABLE != 0);

  typedef enum logic [2:0] {NORMAL, DRAIN, IDLE_PRE, PRBS, IDLE_POST} state_t;

  state_t      state;
  logic [15:0] idle_cnt;
  logic [15:0] drain_cnt;
  logic [63:0] data_q;
  logic [1:0]  hdr_q;
  logic        in_idle;

  assign encoded_tx.data = data_q;
  assign encoded_tx.hdr  = hdr_q;

  // A control block of type 0x1E marks an inter-frame gap: safe point to cut traffic.
  assign in_idle = (enc_tx.hdr == IDLE_HDR) && (enc_tx.data[7:0] == 8'h1E);

  // Outputs are registered from the current state, so every flag trails the state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= NORMAL;
      idle_cnt         <= '0;
      drain_cnt        <= '0;
      data_q           <= IDLE_DATA;
      hdr_q            <= IDLE_HDR;
      tx_prbs31_enable <= 1'b0;
      prbs31_active    <= 1'b0;
      mac_tx_pause     <= 1'b0;
      drain_timeout    <= 1'b0;
    end else begin
      drain_timeout <= 1'b0;
      case (state)
        NORMAL: begin
          data_q           <= enc_tx.data;
          hdr_q            <= enc_tx.hdr;
          mac_tx_pause     <= 1'b0;
          tx_prbs31_enable <= 1'b0;
          prbs31_active    <= 1'b0;
          if (TEST_EN && cfg_prbs31_req) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          data_q           <= enc_tx.data;
          hdr_q            <= enc_tx.hdr;
          mac_tx_pause     <= 1'b1;
          tx_prbs31_enable <= 1'b0;
          prbs31_active    <= 1'b0;
          if (!cfg_prbs31_req) begin
            state <= NORMAL;
          end else if (in_idle) begin
            // Boundary beats a simultaneous timeout, so no pulse here.
            state    <= IDLE_PRE;
            idle_cnt <= '0;
          end else if (drain_cnt == DRAIN_LAST) begin
            state         <= IDLE_PRE;
            idle_cnt      <= '0;
            drain_timeout <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 16'd1;
          end
        end
        IDLE_PRE: begin
          data_q           <= IDLE_DATA;
          hdr_q            <= IDLE_HDR;
          mac_tx_pause     <= 1'b1;
          tx_prbs31_enable <= 1'b0;
          prbs31_active    <= 1'b0;
          if (!cfg_prbs31_req) begin
            state    <= IDLE_POST;
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            state    <= PRBS;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
        PRBS: begin
          data_q           <= IDLE_DATA;
          hdr_q            <= IDLE_HDR;
          mac_tx_pause     <= 1'b1;
          tx_prbs31_enable <= 1'b1;
          prbs31_active    <= 1'b1;
          if (!cfg_prbs31_req) begin
            state    <= IDLE_POST;
            idle_cnt <= '0;
          end
        end
        IDLE_POST: begin
          // Trailing idles let the far-end descrambler and block lock settle; req is ignored.
          data_q           <= IDLE_DATA;
          hdr_q            <= IDLE_HDR;
          mac_tx_pause     <= 1'b1;
          tx_prbs31_enable <= 1'b0;
          prbs31_active    <= 1'b0;
          if (idle_cnt == IDLE_LAST) begin
            state    <= NORMAL;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
        default: begin
          state <= NORMAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_phy_10g_tx_test_ctrl.sv
// tb/tb_eth_phy_10g_tx_test_ctrl.sv - directed self-checking bench for eth_phy_10g_tx_test_ctrl
module tb_eth_phy_10g_tx_test_ctrl;

  localparam logic [63:0] IDLE_DATA = 64'h0000_0000_0000_001E;
  localparam logic [1:0]  IDLE_HDR  = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic req0 = 1'b1;
  logic en, pause, act, tmo;
  logic en0, pause0, act0, tmo0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  eth_phy_10g_tx_test_ctrl_if in_if ();
  eth_phy_10g_tx_test_ctrl_if out_if ();
  eth_phy_10g_tx_test_ctrl_if out0_if ();

  eth_phy_10g_tx_test_ctrl #(
    .PRBS31_ENABLE(1), .IDLE_COUNT(16), .DRAIN_TIMEOUT(32)
  ) dut (
    .clk(clk), .rst(rst), .enc_tx(in_if), .encoded_tx(out_if),
    .tx_prbs31_enable(en), .cfg_prbs31_req(req), .mac_tx_pause(pause),
    .prbs31_active(act), .drain_timeout(tmo)
  );

  eth_phy_10g_tx_test_ctrl #(
    .PRBS31_ENABLE(0), .IDLE_COUNT(16), .DRAIN_TIMEOUT(32)
  ) dut0 (
    .clk(clk), .rst(rst), .enc_tx(in_if), .encoded_tx(out0_if),
    .tx_prbs31_enable(en0), .cfg_prbs31_req(req0), .mac_tx_pause(pause0),
    .prbs31_active(act0), .drain_timeout(tmo0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; the test-mode-disabled instance is checked every cycle.
  task automatic step();
    logic [63:0] ed;
    logic [1:0]  eh;
    ed = rst ? IDLE_DATA : in_if.data;
    eh = rst ? IDLE_HDR  : in_if.hdr;
    @(posedge clk);
    #1;
    chk("p0_data", out0_if.data, ed);
    chk("p0_hdr", 64'(out0_if.hdr), 64'(eh));
    chk("p0_pause", 64'(pause0), 64'd0);
    chk("p0_enable", 64'(en0 | act0 | tmo0), 64'd0);
  endtask

  task automatic drv(input logic [1:0] h, input logic [63:0] d);
    in_if.hdr  = h;
    in_if.data = d;
  endtask

  // Data block (hdr 01) so it is never mistaken for an idle boundary.
  task automatic drv_data(output logic [63:0] d);
    d = {$urandom, $urandom};
    drv(2'b01, d);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_data"}, out_if.data, IDLE_DATA);
    chk({tag, "_hdr"}, 64'(out_if.hdr), 64'(IDLE_HDR));
  endtask

  initial begin
    logic [63:0] d;
    logic [1:0]  h;
    drv(2'b01, 64'h1234_5678_9ABC_DEF0);

    // Reset values
    step();
    chk_idle("rst");
    chk("rst_flags", 64'({en, act, pause, tmo}), 64'd0);
    rst = 1'b0;

    // 1: pass-through with req low
    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom};
      h = 2'($urandom);
      drv(h, d);
      step();
      chk("pt_data", out_if.data, d);
      chk("pt_hdr", 64'(out_if.hdr), 64'(h));
      chk("pt_flags", 64'({en, act, pause, tmo}), 64'd0);
    end

    // 2: request mid-frame, boundary after 5 data blocks, 16 leading idles, then PRBS
    req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drv_data(d);
      step();
      chk("drain_data", out_if.data, d);
      chk("drain_pause", 64'(pause), (i == 0) ? 64'd0 : 64'd1);
    end
    drv(IDLE_HDR, IDLE_DATA);
    step();
    chk_idle("boundary");
    for (int i = 0; i < 16; i++) begin
      drv_data(d);
      step();
      chk_idle("pre");
      chk("pre_en", 64'({en, act}), 64'd0);
      chk("pre_pause", 64'(pause), 64'd1);
    end
    drv_data(d);
    step();
    chk("prbs_en", 64'({en, act}), 64'b11);
    chk_idle("prbs");

    // 3: drop req in PRBS -> 16 trailing idles then pass-through
    drv_data(d);
    step();
    chk("prbs_hold_en", 64'(en), 64'd1);
    req = 1'b0;
    drv_data(d);
    step();
    chk("prbs_last_en", 64'(en), 64'd1);
    for (int i = 0; i < 16; i++) begin
      drv_data(d);
      step();
      chk_idle("post");
      chk("post_en", 64'({en, act}), 64'd0);
      chk("post_pause", 64'(pause), 64'd1);
    end
    drv_data(d);
    step();
    chk("resume_data", out_if.data, d);
    chk("resume_pause", 64'(pause), 64'd0);

    // Request withdrawn during DRAIN -> back to NORMAL, pause falls one cycle later
    req = 1'b1;
    drv_data(d);
    step();
    drv_data(d);
    step();
    chk("abort_pause1", 64'(pause), 64'd1);
    req = 1'b0;
    drv_data(d);
    step();
    chk("abort_pause2", 64'(pause), 64'd1);
    drv_data(d);
    step();
    chk("abort_data", out_if.data, d);
    chk("abort_pause3", 64'(pause), 64'd0);

    // 4: no boundary -> timeout pulse 32 cycles after DRAIN entry
    req = 1'b1;
    drv_data(d);
    step();
    for (int i = 1; i < 32; i++) begin
      drv_data(d);
      step();
      chk("tmo_wait", 64'(tmo), 64'd0);
      chk("tmo_data", out_if.data, d);
    end
    drv_data(d);
    step();
    chk("tmo_pulse", 64'(tmo), 64'd1);
    drv_data(d);
    step();
    chk("tmo_clear", 64'(tmo), 64'd0);
    chk_idle("tmo_pre");

    // 5: req dropped after 3 leading idles -> no PRBS, 16 trailing idles, NORMAL
    for (int i = 0; i < 2; i++) begin
      drv_data(d);
      step();
      chk_idle("ab_pre");
      chk("ab_pre_en", 64'(en), 64'd0);
    end
    req = 1'b0;
    drv_data(d);
    step();
    chk_idle("ab_drop");
    for (int i = 0; i < 16; i++) begin
      drv_data(d);
      step();
      chk_idle("ab_post");
      chk("ab_post_en", 64'(en), 64'd0);
      chk("ab_post_pause", 64'(pause), 64'd1);
    end
    drv_data(d);
    step();
    chk("ab_resume_data", out_if.data, d);
    chk("ab_resume_pause", 64'(pause), 64'd0);

    // 6: reset while in PRBS
    req = 1'b1;
    drv(IDLE_HDR, IDLE_DATA);
    step();
    step();
    for (int i = 0; i < 16; i++) step();
    drv_data(d);
    step();
    chk("rprbs_en", 64'(en), 64'd1);
    rst = 1'b1;
    drv_data(d);
    step();
    chk("rprbs_flags", 64'({en, act, pause, tmo}), 64'd0);
    chk_idle("rprbs");
    rst = 1'b0;
    req = 1'b0;
    drv_data(d);
    step();
    chk("rprbs_resume", out_if.data, d);
    chk("rprbs_pause", 64'(pause), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
